// File: rtl/locked_register_bank_if.sv
// Config-bus bundle for locked_register_bank: write/lock/debug requests in,
// read data, write response, lock state and violation count out.
interface locked_register_bank_if #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int NUM_REGS = 8,
   parameter int VIOL_W   = 8
);
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                lock_en;
   logic [ADDR_W-1:0]   lock_addr;
   logic                lock_all;
   logic                trusted;
   logic                debug_mode;
   logic                dbg_unlock_req;
   logic                dbg_close;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rd_data;
   logic                wr_ack;
   logic                wr_err;
   logic [NUM_REGS-1:0] lock_status;
   logic                dbg_open;
   logic [VIOL_W-1:0]   viol_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, lock_en, lock_addr, lock_all,
             trusted, debug_mode, dbg_unlock_req, dbg_close, rd_addr,
      input  rd_data, wr_ack, wr_err, lock_status, dbg_open, viol_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, lock_en, lock_addr, lock_all,
             trusted, debug_mode, dbg_unlock_req, dbg_close, rd_addr,
      output rd_data, wr_ack, wr_err, lock_status, dbg_open, viol_cnt
   );
endinterface

// File: rtl/locked_register_bank.sv
// Bank of sticky-lockable config registers; trusted debug agents may override
// locks only while a countdown-limited debug window is open.
module locked_register_bank #(
   parameter int DATA_W      = 16,
   parameter int NUM_REGS    = 8,
   parameter int ADDR_W      = 3,
   parameter int DBG_WINDOW  = 64,
   parameter int LOCKOUT_CYC = 256,
   parameter int VIOL_W      = 8
) (
   input logic                   Clk,
   input logic                   resetn,
   locked_register_bank_if.slave bus
);

   localparam int WIN_W = ($clog2(DBG_WINDOW) > 0) ? $clog2(DBG_WINDOW) : 1;
   localparam int LO_W  = ($clog2(LOCKOUT_CYC) > 0) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(DBG_WINDOW - 1);
   localparam logic [LO_W-1:0]   LO_LOAD  = LO_W'(LOCKOUT_CYC - 1);
   localparam logic [ADDR_W:0]   NREG     = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {S_IDLE, S_OPEN, S_LOCKOUT} dbg_state_t;

   function automatic logic [VIOL_W-1:0] sat_inc(input logic [VIOL_W-1:0] v);
      return (&v) ? v : v + VIOL_W'(1);
   endfunction

   dbg_state_t          state, state_nxt;
   logic [WIN_W-1:0]    win_cnt, win_nxt;
   logic [LO_W-1:0]     lo_cnt, lo_nxt;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] lock_bits, lock_set;
   logic [DATA_W-1:0]   rd_data_p1;
   logic                ack_p1, err_p1;
   logic [VIOL_W-1:0]   viol_q;
   logic                trust_ok, wr_in_range, rd_in_range, lock_in_range;
   logic                wr_accept, wr_reject;

   assign trust_ok      = bus.trusted & bus.debug_mode;
   assign wr_in_range   = {1'b0, bus.wr_addr} < NREG;
   assign rd_in_range   = {1'b0, bus.rd_addr} < NREG;
   assign lock_in_range = {1'b0, bus.lock_addr} < NREG;

   // Decision uses pre-edge lock and state, so a same-cycle lock never blocks its write.
   assign wr_accept = bus.wr_en & wr_in_range &
                      (~lock_bits[bus.wr_addr] | ((state == S_OPEN) & trust_ok));
   assign wr_reject = bus.wr_en & ~wr_accept;

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         win_cnt <= '0;
         lo_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         win_cnt <= win_nxt;
         lo_cnt  <= lo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      win_nxt   = win_cnt;
      lo_nxt    = lo_cnt;
      case (state)
         S_IDLE: begin
            if (bus.dbg_unlock_req) begin
               if (trust_ok) begin
                  state_nxt = S_OPEN;
                  win_nxt   = WIN_LOAD;
               end else begin
                  state_nxt = S_LOCKOUT;
                  lo_nxt    = LO_LOAD;
               end
            end
         end
         S_OPEN: begin
            // Further unlock requests are deliberately ignored: the window never extends.
            if (win_cnt == '0 || bus.dbg_close || !trust_ok) begin
               state_nxt = S_IDLE;
               win_nxt   = '0;
            end else begin
               win_nxt = win_cnt - WIN_W'(1);
            end
         end
         S_LOCKOUT: begin
            if (lo_cnt == '0) state_nxt = S_IDLE;
            else              lo_nxt    = lo_cnt - LO_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      lock_set = '0;
      if (bus.lock_all) lock_set = '1;
      if (bus.lock_en && lock_in_range) lock_set[bus.lock_addr] = 1'b1;
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         lock_bits <= '0;
      end else begin
         if (wr_accept) regs[bus.wr_addr] <= bus.wr_data;
         lock_bits <= lock_bits | lock_set;
      end
   end

   // Stage p1: registered read data, write response and violation count
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         rd_data_p1 <= '0;
         ack_p1     <= 1'b0;
         err_p1     <= 1'b0;
         viol_q     <= '0;
      end else begin
         rd_data_p1 <= rd_in_range ? regs[bus.rd_addr] : '0;
         ack_p1     <= wr_accept;
         err_p1     <= wr_reject;
         if (wr_reject && wr_in_range) viol_q <= sat_inc(viol_q);
      end
   end

   assign bus.rd_data     = rd_data_p1;
   assign bus.wr_ack      = ack_p1;
   assign bus.wr_err      = err_p1;
   assign bus.lock_status = lock_bits;
   assign bus.dbg_open    = (state == S_OPEN);
   assign bus.viol_cnt    = viol_q;

endmodule

// File: tb/tb_locked_register_bank.sv
// Directed bench for locked_register_bank: a per-cycle scoreboard of write
// responses and read data plus explicit checks of the debug window FSM.
module tb_locked_register_bank;
   localparam int DATA_W      = 16;
   localparam int NUM_REGS    = 6;
   localparam int ADDR_W      = 3;
   localparam int DBG_WINDOW  = 64;
   localparam int LOCKOUT_CYC = 256;
   localparam int VIOL_W      = 8;

   logic Clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 Clk = ~Clk;

   locked_register_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W),
                             .NUM_REGS(NUM_REGS), .VIOL_W(VIOL_W)) bus ();

   locked_register_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                          .DBG_WINDOW(DBG_WINDOW), .LOCKOUT_CYC(LOCKOUT_CYC),
                          .VIOL_W(VIOL_W)) dut (
      .Clk(Clk), .resetn(resetn), .bus(bus));

   int total = 0;
   int bad   = 0;
   logic [1:0]          resp_q [$];
   logic [DATA_W-1:0]   rd_q [$];
   logic [DATA_W-1:0]   mdl_regs [NUM_REGS];
   logic [NUM_REGS-1:0] mdl_lock;
   logic [VIOL_W-1:0]   mdl_viol;
   logic [1:0]          cur_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = '0;
      mdl_lock = '0;
      mdl_viol = '0;
   endtask

   // exp_ok: 1 = bench expects wr_ack, 0 = bench expects wr_err
   task automatic set_write(input int a, input logic [DATA_W-1:0] d, input bit exp_ok);
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = d;
      cur_exp     = exp_ok ? 2'b10 : 2'b01;
   endtask

   task automatic tick();
      logic [1:0]        r;
      logic [DATA_W-1:0] d;
      resp_q.push_back(cur_exp);
      if (int'(bus.rd_addr) < NUM_REGS) rd_q.push_back(mdl_regs[bus.rd_addr]);
      else                              rd_q.push_back('0);
      if (cur_exp == 2'b10) mdl_regs[bus.wr_addr] = bus.wr_data;
      else if (cur_exp == 2'b01 && int'(bus.wr_addr) < NUM_REGS && mdl_viol != '1)
         mdl_viol = mdl_viol + 1'b1;
      if (bus.lock_all) mdl_lock = '1;
      if (bus.lock_en && int'(bus.lock_addr) < NUM_REGS) mdl_lock[bus.lock_addr] = 1'b1;
      @(posedge Clk);
      #1;
      r = resp_q.pop_front();
      chk("wr_resp", 32'({bus.wr_ack, bus.wr_err}), 32'(r));
      d = rd_q.pop_front();
      chk("rd_data", 32'(bus.rd_data), 32'(d));
      chk("viol_cnt", 32'(bus.viol_cnt), 32'(mdl_viol));
      chk("lock_status", 32'(bus.lock_status), 32'(mdl_lock));
      bus.wr_en          = 1'b0;
      bus.lock_en        = 1'b0;
      bus.lock_all       = 1'b0;
      bus.dbg_unlock_req = 1'b0;
      bus.dbg_close      = 1'b0;
      cur_exp            = 2'b00;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd"}, 32'(bus.rd_data), 32'(0));
      chk({tag, "_resp"}, 32'({bus.wr_ack, bus.wr_err}), 32'(0));
      chk({tag, "_lock"}, 32'(bus.lock_status), 32'(0));
      chk({tag, "_viol"}, 32'(bus.viol_cnt), 32'(0));
      chk({tag, "_open"}, 32'(bus.dbg_open), 32'(0));
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.lock_en = 1'b0; bus.lock_addr = '0; bus.lock_all = 1'b0;
      bus.trusted = 1'b0; bus.debug_mode = 1'b0;
      bus.dbg_unlock_req = 1'b0; bus.dbg_close = 1'b0;
      bus.rd_addr = 3'd2;
      cur_exp = 2'b00;
      model_reset();

      @(posedge Clk);
      #1;
      chk_all_zero("reset");
      resetn = 1'b1;

      // Basic write, same-cycle read returns old value
      set_write(2, 16'hA5A5, 1'b1);
      tick();
      tick();
      chk("rd_after_write", 32'(bus.rd_data), 32'h0000_A5A5);

      // Lock reg 2: writes rejected and counted, other registers unaffected
      bus.lock_en = 1'b1; bus.lock_addr = 3'd2;
      tick();
      set_write(2, 16'h1234, 1'b0);
      tick();
      chk("viol_first", 32'(bus.viol_cnt), 32'd1);
      set_write(3, 16'h5555, 1'b1);
      tick();

      // Write and lock on the same register in one cycle
      set_write(5, 16'h00FF, 1'b1);
      bus.lock_en = 1'b1; bus.lock_addr = 3'd5;
      tick();
      chk("lock5_set", 32'(bus.lock_status[5]), 32'd1);
      bus.rd_addr = 3'd5;
      set_write(5, 16'hAAAA, 1'b0);
      tick();
      tick();
      chk("reg5_kept", 32'(bus.rd_data), 32'h0000_00FF);

      // Out-of-range lock, write and read
      bus.lock_en = 1'b1; bus.lock_addr = 3'd7;
      tick();
      set_write(6, 16'h1111, 1'b0);
      tick();
      bus.rd_addr = 3'd7;
      tick();
      tick();
      bus.rd_addr = 3'd2;

      // Trusted debug window: exactly DBG_WINDOW cycles, re-request does not extend
      bus.trusted = 1'b1; bus.debug_mode = 1'b1; bus.dbg_unlock_req = 1'b1;
      tick();
      for (int k = 0; k < DBG_WINDOW; k++) begin
         chk("win_open", 32'(bus.dbg_open), 32'd1);
         if (k == 10) set_write(2, 16'hBEEF, 1'b1);
         if (k == 20) bus.dbg_unlock_req = 1'b1;
         tick();
      end
      chk("win_closed", 32'(bus.dbg_open), 32'd0);
      set_write(2, 16'hCAFE, 1'b0);
      tick();

      // Untrusted request: lockout ignores requests for LOCKOUT_CYC cycles
      bus.trusted = 1'b0; bus.dbg_unlock_req = 1'b1;
      tick();
      chk("lockout_entry", 32'(bus.dbg_open), 32'd0);
      for (int j = 1; j <= LOCKOUT_CYC; j++) begin
         bus.trusted = 1'b1; bus.dbg_unlock_req = 1'b1;
         tick();
         chk("lockout_hold", 32'(bus.dbg_open), 32'd0);
      end
      bus.dbg_unlock_req = 1'b1;
      tick();
      chk("lockout_release", 32'(bus.dbg_open), 32'd1);

      // Trust drops with a debug write in the same cycle: rejected, window closes
      bus.trusted = 1'b0;
      set_write(2, 16'h7777, 1'b0);
      tick();
      chk("abort_close", 32'(bus.dbg_open), 32'd0);

      // Early close
      bus.trusted = 1'b1; bus.dbg_unlock_req = 1'b1;
      tick();
      chk("reopen", 32'(bus.dbg_open), 32'd1);
      set_write(2, 16'h1357, 1'b1);
      tick();
      bus.dbg_close = 1'b1;
      tick();
      chk("dbg_close", 32'(bus.dbg_open), 32'd0);

      // lock_all, then saturate the violation counter
      bus.trusted = 1'b0;
      bus.lock_all = 1'b1;
      tick();
      set_write(0, 16'h4242, 1'b0);
      tick();
      for (int i = 0; i < 300; i++) begin
         set_write(1, 16'h9999, 1'b0);
         tick();
      end
      chk("viol_sat", 32'(bus.viol_cnt), 32'd255);

      // Asynchronous reset in the middle of an open window
      bus.trusted = 1'b1; bus.dbg_unlock_req = 1'b1;
      tick();
      set_write(0, 16'h8888, 1'b1);
      tick();
      chk("pre_reset_open", 32'(bus.dbg_open), 32'd1);
      resetn = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      #1;
      resetn = 1'b1;
      tick();
      set_write(2, 16'h2468, 1'b1);
      tick();
      tick();
      chk("post_reset_write", 32'(bus.rd_data), 32'h0000_2468);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
